reg_file: RTL and testbench

//  Architectural register file with per-register rename tags, sitting directly upstream of the dispatcher.
//  - Answers the dispatcher's rs1/rs2 queries with either a ready value or the producing RoB index.
//  - Records the RoB index of each newly dispatched rd.
//  - Takes commits from the RoB and clears all tags on a RoB flush (mispredict).

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_rf_read_port.sv | 35 +++
 rtl/reg_file.sv | 90 +++++++++
 tb/tb_reg_file.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file / rename-tag parameters used by the dispatcher, RoB, RS and LSB.
package reg_file_pkg;

    localparam int unsigned REG_WIDTH    = 5;
    localparam int unsigned EX_REG_WIDTH = REG_WIDTH + 1;
    localparam int unsigned NUM_REGS     = 1 << REG_WIDTH;
    localparam int unsigned RoB_WIDTH    = 4;
    localparam int unsigned EX_RoB_WIDTH = RoB_WIDTH + 1;
    localparam int unsigned DATA_WIDTH   = 32;

    localparam logic [EX_REG_WIDTH-1:0] NON_REG = EX_REG_WIDTH'(1 << REG_WIDTH);
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = EX_RoB_WIDTH'(1 << RoB_WIDTH);

    // True for x1..x31; false for x0 and any "no register" encoding.
    function automatic logic is_arch_reg(input logic [EX_REG_WIDTH-1:0] rd);
        return (rd[EX_REG_WIDTH-1] == 1'b0) && (rd[REG_WIDTH-1:0] != '0);
    endfunction

endpackage

// File: rtl/reg_file_rf_read_port.sv
// One operand query: resolves a register to a ready value or its producing RoB tag,
// including a bypass of the commit happening this same cycle.
module rf_read_port
    import reg_file_pkg::*;
(
    input  logic [EX_REG_WIDTH-1:0] i_rs,
    input  logic [EX_RoB_WIDTH-1:0] i_tag,
    input  logic [DATA_WIDTH-1:0]   i_val,
    input  logic                    i_cm_en,
    input  logic [EX_REG_WIDTH-1:0] i_cm_rd,
    input  logic [RoB_WIDTH-1:0]    i_cm_index,
    input  logic [DATA_WIDTH-1:0]   i_cm_data,
    output logic [EX_RoB_WIDTH-1:0] o_q,
    output logic [DATA_WIDTH-1:0]   o_v
);

    logic w_bypass;

    assign w_bypass = i_cm_en && (i_cm_rd == i_rs) && ({1'b0, i_cm_index} == i_tag);

    always_comb begin
        o_q = NON_DEP;
        o_v = '0;
        if (is_arch_reg(i_rs)) begin
            if (i_tag == NON_DEP) begin
                o_v = i_val;
            end else if (w_bypass) begin
                o_v = i_cm_data;
            end else begin
                o_q = i_tag;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags feeding the dispatcher.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [EX_REG_WIDTH-1:0] DP2RF_rs1,
    input  logic [EX_REG_WIDTH-1:0] DP2RF_rs2,
    output logic [EX_RoB_WIDTH-1:0] RF2DP_Qj,
    output logic [EX_RoB_WIDTH-1:0] RF2DP_Qk,
    output logic [DATA_WIDTH-1:0]   RF2DP_Vj,
    output logic [DATA_WIDTH-1:0]   RF2DP_Vk,
    input  logic                    DP2RF_en,
    input  logic [EX_REG_WIDTH-1:0] DP2RF_rd,
    input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
    input  logic                    RoB2RF_en,
    input  logic [EX_REG_WIDTH-1:0] RoB2RF_rd,
    input  logic [RoB_WIDTH-1:0]    RoB2RF_index,
    input  logic [DATA_WIDTH-1:0]   RoB2RF_data,
    input  logic                    RoB2RF_clear
);

    logic [DATA_WIDTH-1:0]   r_val [NUM_REGS];
    logic [EX_RoB_WIDTH-1:0] r_tag [NUM_REGS];

    logic [EX_RoB_WIDTH-1:0] w_tag_j;
    logic [EX_RoB_WIDTH-1:0] w_tag_k;
    logic [DATA_WIDTH-1:0]   w_val_j;
    logic [DATA_WIDTH-1:0]   w_val_k;
    logic                    w_commit;
    logic                    w_rename;

    assign w_commit = RoB2RF_en && is_arch_reg(RoB2RF_rd);
    assign w_rename = DP2RF_en && is_arch_reg(DP2RF_rd) && !RoB2RF_clear;

    // Later non-blocking writes win: clear beats rename, rename beats commit's tag release.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_val[i] <= '0;
                r_tag[i] <= NON_DEP;
            end
        end else if (rdy_in) begin
            if (w_commit) begin
                r_val[RoB2RF_rd[REG_WIDTH-1:0]] <= RoB2RF_data;
                if (r_tag[RoB2RF_rd[REG_WIDTH-1:0]] == {1'b0, RoB2RF_index}) begin
                    r_tag[RoB2RF_rd[REG_WIDTH-1:0]] <= NON_DEP;
                end
            end
            if (RoB2RF_clear) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    r_tag[i] <= NON_DEP;
                end
            end else if (w_rename) begin
                r_tag[DP2RF_rd[REG_WIDTH-1:0]] <= {1'b0, DPRF_RoB_index};
            end
        end
    end

    assign w_tag_j = r_tag[DP2RF_rs1[REG_WIDTH-1:0]];
    assign w_val_j = r_val[DP2RF_rs1[REG_WIDTH-1:0]];
    assign w_tag_k = r_tag[DP2RF_rs2[REG_WIDTH-1:0]];
    assign w_val_k = r_val[DP2RF_rs2[REG_WIDTH-1:0]];

    rf_read_port u_port_j (
        .i_rs       (DP2RF_rs1),
        .i_tag      (w_tag_j),
        .i_val      (w_val_j),
        .i_cm_en    (RoB2RF_en),
        .i_cm_rd    (RoB2RF_rd),
        .i_cm_index (RoB2RF_index),
        .i_cm_data  (RoB2RF_data),
        .o_q        (RF2DP_Qj),
        .o_v        (RF2DP_Vj)
    );

    rf_read_port u_port_k (
        .i_rs       (DP2RF_rs2),
        .i_tag      (w_tag_k),
        .i_val      (w_val_k),
        .i_cm_en    (RoB2RF_en),
        .i_cm_rd    (RoB2RF_rd),
        .i_cm_index (RoB2RF_index),
        .i_cm_data  (RoB2RF_data),
        .o_q        (RF2DP_Qk),
        .o_v        (RF2DP_Vk)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  DP2RF_rs1, DP2RF_rs2;
    logic [4:0]  RF2DP_Qj, RF2DP_Qk;
    logic [31:0] RF2DP_Vj, RF2DP_Vk;
    logic        DP2RF_en;
    logic [5:0]  DP2RF_rd;
    logic [3:0]  DPRF_RoB_index;
    logic        RoB2RF_en;
    logic [5:0]  RoB2RF_rd;
    logic [3:0]  RoB2RF_index;
    logic [31:0] RoB2RF_data;
    logic        RoB2RF_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    reg_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .DP2RF_rs1(DP2RF_rs1), .DP2RF_rs2(DP2RF_rs2),
        .RF2DP_Qj(RF2DP_Qj), .RF2DP_Qk(RF2DP_Qk),
        .RF2DP_Vj(RF2DP_Vj), .RF2DP_Vk(RF2DP_Vk),
        .DP2RF_en(DP2RF_en), .DP2RF_rd(DP2RF_rd), .DPRF_RoB_index(DPRF_RoB_index),
        .RoB2RF_en(RoB2RF_en), .RoB2RF_rd(RoB2RF_rd), .RoB2RF_index(RoB2RF_index),
        .RoB2RF_data(RoB2RF_data), .RoB2RF_clear(RoB2RF_clear)
    );

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        DP2RF_en = 1'b0; RoB2RF_en = 1'b0; RoB2RF_clear = 1'b0;
        DP2RF_rd = 6'd32; RoB2RF_rd = 6'd32;
        DPRF_RoB_index = '0; RoB2RF_index = '0; RoB2RF_data = '0;
    endtask

    task automatic rename(input logic [5:0] rd, input logic [3:0] idx);
        DP2RF_en = 1'b1; DP2RF_rd = rd; DPRF_RoB_index = idx;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        idle();
        DP2RF_rs1 = 6'd5; DP2RF_rs2 = 6'd32;
        step(); step();
        #1;
        checks++; if (RF2DP_Qj !== 5'd16) begin errors++; $display("FAIL reset_qj got %0d exp 16", RF2DP_Qj); end
        checks++; if (RF2DP_Vj !== 32'd0) begin errors++; $display("FAIL reset_vj got %h exp 0", RF2DP_Vj); end
        checks++; if (RF2DP_Qk !== 5'd16) begin errors++; $display("FAIL reset_qk got %0d exp 16", RF2DP_Qk); end
        checks++; if (RF2DP_Vk !== 32'd0) begin errors++; $display("FAIL reset_vk got %h exp 0", RF2DP_Vk); end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_rename_commit();
        rename(6'd3, 4'd7);
        DP2RF_rs1 = 6'd3; DP2RF_rs2 = 6'd3;
        #1;
        checks++; if (RF2DP_Qj !== 5'd7) begin errors++; $display("FAIL rename_qj got %0d exp 7", RF2DP_Qj); end
        checks++; if (RF2DP_Qk !== 5'd7) begin errors++; $display("FAIL rename_qk got %0d exp 7", RF2DP_Qk); end
        checks++; if (RF2DP_Vj !== 32'd0) begin errors++; $display("FAIL rename_vj got %h exp 0", RF2DP_Vj); end
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd3; RoB2RF_index = 4'd7; RoB2RF_data = 32'hDEADBEEF;
        #1;
        checks++; if (RF2DP_Qj !== 5'd16) begin errors++; $display("FAIL bypass_qj got %0d exp 16", RF2DP_Qj); end
        checks++; if (RF2DP_Vj !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_vj got %h exp deadbeef", RF2DP_Vj); end
        checks++; if (RF2DP_Vk !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_vk got %h exp deadbeef", RF2DP_Vk); end
        step();
        idle();
        #1;
        checks++; if (RF2DP_Qj !== 5'd16) begin errors++; $display("FAIL commit_qj got %0d exp 16", RF2DP_Qj); end
        checks++; if (RF2DP_Vj !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_vj got %h exp deadbeef", RF2DP_Vj); end
    endtask

    task automatic test_younger_producer();
        rename(6'd4, 4'd2);
        rename(6'd4, 4'd9);
        DP2RF_rs1 = 6'd4; DP2RF_rs2 = 6'd32;
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd4; RoB2RF_index = 4'd2; RoB2RF_data = 32'h11;
        #1;
        checks++; if (RF2DP_Qj !== 5'd9) begin errors++; $display("FAIL stale_bypass_qj got %0d exp 9", RF2DP_Qj); end
        step();
        idle();
        #1;
        checks++; if (RF2DP_Qj !== 5'd9) begin errors++; $display("FAIL younger_qj got %0d exp 9", RF2DP_Qj); end
        checks++; if (RF2DP_Vj !== 32'd0) begin errors++; $display("FAIL younger_vj got %h exp 0", RF2DP_Vj); end
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd4; RoB2RF_index = 4'd9; RoB2RF_data = 32'h33;
        step();
        idle();
        #1;
        checks++; if (RF2DP_Qj !== 5'd16) begin errors++; $display("FAIL younger_done_qj got %0d exp 16", RF2DP_Qj); end
        checks++; if (RF2DP_Vj !== 32'h33) begin errors++; $display("FAIL younger_done_vj got %h exp 33", RF2DP_Vj); end
    endtask

    task automatic test_back_to_back();
        rename(6'd6, 4'd12);
        DP2RF_en = 1'b1; DP2RF_rd = 6'd6; DPRF_RoB_index = 4'd5;
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd6; RoB2RF_index = 4'd12; RoB2RF_data = 32'h22;
        step();
        idle();
        DP2RF_rs1 = 6'd32; DP2RF_rs2 = 6'd6;
        #1;
        checks++; if (RF2DP_Qk !== 5'd5) begin errors++; $display("FAIL same_cycle_qk got %0d exp 5", RF2DP_Qk); end
        checks++; if (RF2DP_Vk !== 32'd0) begin errors++; $display("FAIL same_cycle_vk got %h exp 0", RF2DP_Vk); end
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd6; RoB2RF_index = 4'd5; RoB2RF_data = 32'h44;
        step();
        idle();
        #1;
        checks++; if (RF2DP_Qk !== 5'd16) begin errors++; $display("FAIL final_qk got %0d exp 16", RF2DP_Qk); end
        checks++; if (RF2DP_Vk !== 32'h44) begin errors++; $display("FAIL final_vk got %h exp 44", RF2DP_Vk); end
    endtask

    task automatic test_clear();
        rename(6'd1, 4'd1);
        rename(6'd2, 4'd2);
        DP2RF_rs1 = 6'd1; DP2RF_rs2 = 6'd2;
        #1;
        checks++; if (RF2DP_Qk !== 5'd2) begin errors++; $display("FAIL pre_clear_qk got %0d exp 2", RF2DP_Qk); end
        RoB2RF_clear = 1'b1; DP2RF_en = 1'b1; DP2RF_rd = 6'd8; DPRF_RoB_index = 4'd3;
        step();
        idle();
        #1;
        checks++; if (RF2DP_Qj !== 5'd16 || RF2DP_Vj !== 32'd0) begin errors++; $display("FAIL clear_x1 got q=%0d v=%h exp q=16 v=0", RF2DP_Qj, RF2DP_Vj); end
        checks++; if (RF2DP_Qk !== 5'd16 || RF2DP_Vk !== 32'd0) begin errors++; $display("FAIL clear_x2 got q=%0d v=%h exp q=16 v=0", RF2DP_Qk, RF2DP_Vk); end
        DP2RF_rs1 = 6'd8; DP2RF_rs2 = 6'd3;
        #1;
        checks++; if (RF2DP_Qj !== 5'd16) begin errors++; $display("FAIL clear_x8_qj got %0d exp 16", RF2DP_Qj); end
        checks++; if (RF2DP_Vk !== 32'hDEADBEEF) begin errors++; $display("FAIL clear_keeps_val got %h exp deadbeef", RF2DP_Vk); end
        // Commit alongside a flush still lands its value.
        rename(6'd1, 4'd1);
        RoB2RF_clear = 1'b1;
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd1; RoB2RF_index = 4'd1; RoB2RF_data = 32'h55;
        step();
        idle();
        DP2RF_rs1 = 6'd1;
        #1;
        checks++; if (RF2DP_Qj !== 5'd16 || RF2DP_Vj !== 32'h55) begin errors++; $display("FAIL clear_commit got q=%0d v=%h exp q=16 v=55", RF2DP_Qj, RF2DP_Vj); end
    endtask

    task automatic test_x0_and_rdy();
        DP2RF_en = 1'b1; DP2RF_rd = 6'd0; DPRF_RoB_index = 4'd3;
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd0; RoB2RF_index = 4'd3; RoB2RF_data = 32'hFF;
        DP2RF_rs1 = 6'd0; DP2RF_rs2 = 6'd0;
        #1;
        checks++; if (RF2DP_Vj !== 32'd0) begin errors++; $display("FAIL x0_bypass_vj got %h exp 0", RF2DP_Vj); end
        step();
        idle();
        #1;
        checks++; if (RF2DP_Qj !== 5'd16 || RF2DP_Vj !== 32'd0) begin errors++; $display("FAIL x0_j got q=%0d v=%h exp q=16 v=0", RF2DP_Qj, RF2DP_Vj); end
        checks++; if (RF2DP_Qk !== 5'd16 || RF2DP_Vk !== 32'd0) begin errors++; $display("FAIL x0_k got q=%0d v=%h exp q=16 v=0", RF2DP_Qk, RF2DP_Vk); end
        rdy_in = 1'b0;
        DP2RF_en = 1'b1; DP2RF_rd = 6'd9; DPRF_RoB_index = 4'd4;
        RoB2RF_en = 1'b1; RoB2RF_rd = 6'd6; RoB2RF_index = 4'd0; RoB2RF_data = 32'h99;
        step();
        idle();
        rdy_in = 1'b1;
        DP2RF_rs1 = 6'd9; DP2RF_rs2 = 6'd6;
        #1;
        checks++; if (RF2DP_Qj !== 5'd16) begin errors++; $display("FAIL rdy_hold_tag got %0d exp 16", RF2DP_Qj); end
        checks++; if (RF2DP_Vk !== 32'h44) begin errors++; $display("FAIL rdy_hold_val got %h exp 44", RF2DP_Vk); end
    endtask

    initial begin
        test_reset();
        test_rename_commit();
        test_younger_producer();
        test_back_to_back();
        test_clear();
        test_x0_and_rdy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
